centroid_overlay: RTL and testbench

- Consumes the centroid result interface produced by the clustering stage: 7 centroid X/Y coordinates, num_balls, a one-cycle data_valid pulse, and new_frame.
- Draws a square outline marker around each active centroid onto a 320x180 pixel stream headed to the display path.
- Centroid sets are double-buffered, so markers change only on frame boundaries and never tear mid-frame.

---
 rtl/centroid_overlay.sv | 171 +++++++++++++++++
 tb/tb_centroid_overlay.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_overlay.sv
// centroid_overlay: draws square outline markers around up to 7 centroids onto
// a 320x180 RGB565 pixel stream, with a fixed 2-cycle latency.
// Centroid sets are double-buffered (shadow -> active) and swap only on
// new_frame, so markers never tear mid-frame.
//
// Ports:
//   clk_in, rst_in             clock, synchronous active-high reset
//   centroids_x_in/_y_in       7 centroid coordinates from the clustering stage
//   num_balls                  count of valid centroids (indices 0..num_balls-1)
//   data_valid_in              one-cycle capture strobe for centroids/num_balls
//   new_frame                  one-cycle frame-start strobe (swap point)
//   hcount_in/vcount_in        pixel coordinates
//   pixel_valid_in/pixel_in    source pixel stream
//   pixel_out/pixel_valid_out  output stream, marker colour where hit
//   hit_out/hit_index_out      marker hit flag and lowest hit index
module centroid_overlay #(
    parameter int unsigned BOX_HALF = 4,
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 180
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [6:0][8:0] centroids_x_in,
    input  logic [6:0][7:0] centroids_y_in,
    input  logic [2:0]      num_balls,
    input  logic            data_valid_in,
    input  logic            new_frame,
    input  logic [8:0]      hcount_in,
    input  logic [7:0]      vcount_in,
    input  logic            pixel_valid_in,
    input  logic [15:0]     pixel_in,
    output logic [15:0]     pixel_out,
    output logic            pixel_valid_out,
    output logic            hit_out,
    output logic [2:0]      hit_index_out
);

    localparam int unsigned N  = 7;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned DW = 10;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 3;

    // Index 0 is the least significant entry.
    localparam logic [N-1:0][PW-1:0] PALETTE = {
        16'hFFFF, 16'h07FF, 16'hF81F, 16'hFFE0, 16'h001F, 16'h07E0, 16'hF800
    };

    logic [N-1:0][XW-1:0] shadow_x, active_x;
    logic [N-1:0][YW-1:0] shadow_y, active_y;
    logic [CW-1:0]        shadow_count, active_count;
    logic                 pending;

    // Double-buffered centroid capture and frame-boundary swap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_count <= '0;
            active_x     <= '0;
            active_y     <= '0;
            active_count <= '0;
            pending      <= 1'b0;
        end else if (data_valid_in && new_frame) begin
            // Simultaneous capture and frame start: the fresh set goes live now.
            shadow_x     <= centroids_x_in;
            shadow_y     <= centroids_y_in;
            shadow_count <= num_balls;
            active_x     <= centroids_x_in;
            active_y     <= centroids_y_in;
            active_count <= num_balls;
            pending      <= 1'b0;
        end else if (data_valid_in) begin
            shadow_x     <= centroids_x_in;
            shadow_y     <= centroids_y_in;
            shadow_count <= num_balls;
            pending      <= 1'b1;
        end else if (new_frame && pending) begin
            active_x     <= shadow_x;
            active_y     <= shadow_y;
            active_count <= shadow_count;
            pending      <= 1'b0;
        end
    end

    // Stage 1 combinational: absolute distances in 10-bit signed arithmetic.
    logic [DW-1:0] dx_c  [N];
    logic [DW-1:0] dy_c  [N];
    logic [DW-1:0] adx_c [N];
    logic [DW-1:0] ady_c [N];
    logic [N-1:0]  en_c;
    logic          in_frame_c;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            dx_c[i]  = DW'(hcount_in) - DW'(active_x[i]);
            dy_c[i]  = DW'(vcount_in) - DW'(active_y[i]);
            adx_c[i] = dx_c[i][DW-1] ? DW'(-dx_c[i]) : dx_c[i];
            ady_c[i] = dy_c[i][DW-1] ? DW'(-dy_c[i]) : dy_c[i];
            en_c[i]  = CW'(i) < active_count;
        end
        in_frame_c = (hcount_in < XW'(WIDTH)) && (vcount_in < YW'(HEIGHT));
    end

    logic [DW-1:0] adx_q [N];
    logic [DW-1:0] ady_q [N];
    logic [N-1:0]  en_q;
    logic          in_frame_q;
    logic          valid_q;
    logic [PW-1:0] pixel_q;

    // Stage 1 registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(N); i++) begin
                adx_q[i] <= '0;
                ady_q[i] <= '0;
            end
            en_q       <= '0;
            in_frame_q <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                adx_q[i] <= adx_c[i];
                ady_q[i] <= ady_c[i];
            end
            en_q       <= en_c;
            in_frame_q <= in_frame_c;
            valid_q    <= pixel_valid_in;
            pixel_q    <= pixel_in;
        end
    end

    // Stage 2 combinational: outline test; scanning downward leaves the lowest hit index.
    logic          hit_c;
    logic [CW-1:0] hit_idx_c;
    logic [PW-1:0] pix_c;
    logic [DW-1:0] dmax_c [N];

    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        pix_c     = pixel_q;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            dmax_c[i] = (adx_q[i] > ady_q[i]) ? adx_q[i] : ady_q[i];
            if (en_q[i] && in_frame_q && (dmax_c[i] == DW'(BOX_HALF))) begin
                hit_c     = 1'b1;
                hit_idx_c = CW'(i);
                pix_c     = PALETTE[i];
            end
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            hit_out         <= 1'b0;
            hit_index_out   <= '0;
        end else begin
            pixel_out       <= pix_c;
            pixel_valid_out <= valid_q;
            hit_out         <= hit_c;
            hit_index_out   <= hit_idx_c;
        end
    end

endmodule

// File: tb/tb_centroid_overlay.sv
// Directed self-checking bench for centroid_overlay.
module tb_centroid_overlay;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [6:0][8:0] centroids_x_in;
    logic [6:0][7:0] centroids_y_in;
    logic [2:0]      num_balls;
    logic            data_valid_in;
    logic            new_frame;
    logic [8:0]      hcount_in;
    logic [7:0]      vcount_in;
    logic            pixel_valid_in;
    logic [15:0]     pixel_in;
    logic [15:0]     pixel_out;
    logic            pixel_valid_out;
    logic            hit_out;
    logic [2:0]      hit_index_out;

    int tests  = 0;
    int failed = 0;

    // Results of the most recent probe.
    logic [15:0] po;
    logic        ho;
    logic [2:0]  hio;
    logic        vo;

    localparam logic [15:0] SRC = 16'h1234;

    centroid_overlay dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .centroids_x_in  (centroids_x_in),
        .centroids_y_in  (centroids_y_in),
        .num_balls       (num_balls),
        .data_valid_in   (data_valid_in),
        .new_frame       (new_frame),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_in        (pixel_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .hit_out         (hit_out),
        .hit_index_out   (hit_index_out)
    );

    always #5 clk_in = ~clk_in;

    // Drive one pixel and return the outputs it produces two cycles later.
    task automatic probe(input int h, input int v);
        @(negedge clk_in);
        hcount_in      = 9'(h);
        vcount_in      = 8'(v);
        pixel_in       = SRC;
        pixel_valid_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        po  = pixel_out;
        ho  = hit_out;
        hio = hit_index_out;
        vo  = pixel_valid_out;
    endtask

    task automatic capture(input logic [6:0][8:0] cx, input logic [6:0][7:0] cy,
                           input int n, input logic with_frame);
        @(negedge clk_in);
        centroids_x_in = cx;
        centroids_y_in = cy;
        num_balls      = 3'(n);
        data_valid_in  = 1'b1;
        new_frame      = with_frame;
        @(negedge clk_in);
        data_valid_in  = 1'b0;
        new_frame      = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk_in);
        new_frame = 1'b1;
        @(negedge clk_in);
        new_frame = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        pixel_valid_in = 1'b1;
        pixel_in = SRC;
        repeat (3) @(negedge clk_in);
        tests++;
        if (pixel_out !== 16'h0 || pixel_valid_out !== 1'b0 || hit_out !== 1'b0 || hit_index_out !== 3'd0) begin
            failed++;
            $display("FAIL reset: pixel_out=%h valid=%b hit=%b idx=%0d, required 0000 0 0 0",
                     pixel_out, pixel_valid_out, hit_out, hit_index_out);
        end
        rst_in = 1'b0;
    endtask

    // Streaming passthrough with no capture: output equals input from two cycles earlier.
    task automatic test_passthrough();
        logic [15:0] hist_p [$];
        logic        hist_v [$];
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_in);
            if (k >= 2) begin
                tests++;
                if (pixel_out !== hist_p[k-2] || pixel_valid_out !== hist_v[k-2] || hit_out !== 1'b0) begin
                    failed++;
                    $display("FAIL passthrough k=%0d: pixel=%h valid=%b hit=%b, required %h %b 0",
                             k, pixel_out, pixel_valid_out, hit_out, hist_p[k-2], hist_v[k-2]);
                end
            end
            hcount_in      = 9'(96 + k);
            vcount_in      = 8'(46 + (k % 9));
            pixel_in       = SRC + 16'(k);
            pixel_valid_in = (k % 3) != 1;
            hist_p.push_back(pixel_in);
            hist_v.push_back(pixel_valid_in);
        end
    endtask

    task automatic test_single();
        logic [6:0][8:0] cx = '0;
        logic [6:0][7:0] cy = '0;
        int hx[5] = '{104, 96, 100, 100, 103};
        int hy[5] = '{50, 46, 54, 50, 50};
        logic hit_exp[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cx[0] = 9'd100; cy[0] = 8'd50;
        capture(cx, cy, 1, 1'b0);
        frame_start();
        for (int k = 0; k < 5; k++) begin
            probe(hx[k], hy[k]);
            tests++;
            if (ho !== hit_exp[k] || hio !== 3'd0 || po !== (hit_exp[k] ? 16'hF800 : SRC) || vo !== 1'b1) begin
                failed++;
                $display("FAIL single (%0d,%0d): hit=%b idx=%0d pixel=%h, required hit=%b idx=0 pixel=%h",
                         hx[k], hy[k], ho, hio, po, hit_exp[k], hit_exp[k] ? 16'hF800 : SRC);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0][8:0] cx = '0;
        logic [6:0][7:0] cy = '0;
        cx[0] = 9'd100; cy[0] = 8'd50;
        cx[1] = 9'd102; cy[1] = 8'd50;
        capture(cx, cy, 2, 1'b0);
        frame_start();
        probe(104, 54);
        tests++;
        if (ho !== 1'b1 || hio !== 3'd0 || po !== 16'hF800) begin
            failed++;
            $display("FAIL overlap_low (104,54): hit=%b idx=%0d pixel=%h, required 1 0 F800", ho, hio, po);
        end
        probe(106, 50);
        tests++;
        if (ho !== 1'b1 || hio !== 3'd1 || po !== 16'h07E0) begin
            failed++;
            $display("FAIL overlap_c1 (106,50): hit=%b idx=%0d pixel=%h, required 1 1 07E0", ho, hio, po);
        end
    endtask

    task automatic test_disabled();
        logic [6:0][8:0] cx = '0;
        logic [6:0][7:0] cy = '0;
        cx[0] = 9'd100; cy[0] = 8'd50;
        cx[1] = 9'd200; cy[1] = 8'd100;
        capture(cx, cy, 1, 1'b0);
        frame_start();
        probe(204, 100);
        tests++;
        if (ho !== 1'b0 || po !== SRC) begin
            failed++;
            $display("FAIL disabled (204,100): hit=%b pixel=%h, required 0 %h", ho, po, SRC);
        end
        probe(104, 50);
        tests++;
        if (ho !== 1'b1 || po !== 16'hF800) begin
            failed++;
            $display("FAIL enabled_c0 (104,50): hit=%b pixel=%h, required 1 F800", ho, po);
        end
    endtask

    task automatic test_all_seven();
        logic [6:0][8:0] cx = '0;
        logic [6:0][7:0] cy = '0;
        for (int i = 0; i < 7; i++) begin
            cx[i] = 9'(20 + 20 * i);
            cy[i] = 8'd30;
        end
        capture(cx, cy, 7, 1'b0);
        frame_start();
        probe(144, 30);
        tests++;
        if (ho !== 1'b1 || hio !== 3'd6 || po !== 16'hFFFF) begin
            failed++;
            $display("FAIL seven_c6 (144,30): hit=%b idx=%0d pixel=%h, required 1 6 FFFF", ho, hio, po);
        end
        probe(44, 30);
        tests++;
        if (ho !== 1'b1 || hio !== 3'd1 || po !== 16'h07E0) begin
            failed++;
            $display("FAIL seven_c1 (44,30): hit=%b idx=%0d pixel=%h, required 1 1 07E0", ho, hio, po);
        end
    endtask

    task automatic test_mid_frame();
        logic [6:0][8:0] cx = '0;
        logic [6:0][7:0] cy = '0;
        cx[0] = 9'd100; cy[0] = 8'd50;
        capture(cx, cy, 1, 1'b0);
        frame_start();
        cx[0] = 9'd10; cy[0] = 8'd10;
        capture(cx, cy, 1, 1'b0);
        probe(104, 50);
        tests++;
        if (ho !== 1'b1) begin
            failed++;
            $display("FAIL mid_old_kept (104,50): hit=%b, required 1", ho);
        end
        probe(14, 10);
        tests++;
        if (ho !== 1'b0) begin
            failed++;
            $display("FAIL mid_new_early (14,10): hit=%b, required 0", ho);
        end
        frame_start();
        probe(14, 10);
        tests++;
        if (ho !== 1'b1 || po !== 16'hF800) begin
            failed++;
            $display("FAIL mid_new_live (14,10): hit=%b pixel=%h, required 1 F800", ho, po);
        end
        probe(104, 50);
        tests++;
        if (ho !== 1'b0) begin
            failed++;
            $display("FAIL mid_old_gone (104,50): hit=%b, required 0", ho);
        end
        cx[0] = 9'd50; cy[0] = 8'd60;
        capture(cx, cy, 1, 1'b1);
        probe(54, 60);
        tests++;
        if (ho !== 1'b1) begin
            failed++;
            $display("FAIL simultaneous (54,60): hit=%b, required 1", ho);
        end
        probe(14, 10);
        tests++;
        if (ho !== 1'b0) begin
            failed++;
            $display("FAIL simultaneous_old (14,10): hit=%b, required 0", ho);
        end
        frame_start();
        probe(54, 60);
        tests++;
        if (ho !== 1'b1) begin
            failed++;
            $display("FAIL swap_no_pending (54,60): hit=%b, required 1", ho);
        end
    endtask

    task automatic test_edges();
        logic [6:0][8:0] cx = '0;
        logic [6:0][7:0] cy = '0;
        int hx[7] = '{6, 0, 2, 318, 316, 2, 0};
        int hy[7] = '{1, 5, 5, 1, 1, 177, 0};
        logic hit_exp[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        cx[0] = 9'd2; cy[0] = 8'd1;
        capture(cx, cy, 1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            probe(hx[k], hy[k]);
            tests++;
            if (ho !== hit_exp[k]) begin
                failed++;
                $display("FAIL edge (%0d,%0d): hit=%b, required %b", hx[k], hy[k], ho, hit_exp[k]);
            end
        end
        cx[0] = 9'd0; cy[0] = 8'd0;
        capture(cx, cy, 1, 1'b1);
        probe(4, 2);
        tests++;
        if (ho !== 1'b1) begin
            failed++;
            $display("FAIL origin_right (4,2): hit=%b, required 1", ho);
        end
        probe(2, 4);
        tests++;
        if (ho !== 1'b1) begin
            failed++;
            $display("FAIL origin_bottom (2,4): hit=%b, required 1", ho);
        end
        cx[0] = 9'd316; cy[0] = 8'd176;
        capture(cx, cy, 1, 1'b1);
        probe(312, 176);
        tests++;
        if (ho !== 1'b1) begin
            failed++;
            $display("FAIL clip_inside (312,176): hit=%b, required 1", ho);
        end
        probe(320, 176);
        tests++;
        if (ho !== 1'b0 || po !== SRC) begin
            failed++;
            $display("FAIL clip_x (320,176): hit=%b pixel=%h, required 0 %h", ho, po, SRC);
        end
        probe(316, 180);
        tests++;
        if (ho !== 1'b0) begin
            failed++;
            $display("FAIL clip_y (316,180): hit=%b, required 0", ho);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk_in);
        hcount_in = 9'd312;
        vcount_in = 8'd176;
        pixel_valid_in = 1'b1;
        rst_in = 1'b1;
        @(negedge clk_in);
        tests++;
        if (pixel_out !== 16'h0 || pixel_valid_out !== 1'b0 || hit_out !== 1'b0 || hit_index_out !== 3'd0) begin
            failed++;
            $display("FAIL reset_mid: pixel=%h valid=%b hit=%b idx=%0d, required 0000 0 0 0",
                     pixel_out, pixel_valid_out, hit_out, hit_index_out);
        end
        rst_in = 1'b0;
        frame_start();
        probe(312, 176);
        tests++;
        if (ho !== 1'b0 || po !== SRC || vo !== 1'b1) begin
            failed++;
            $display("FAIL reset_no_marker (312,176): hit=%b pixel=%h valid=%b, required 0 %h 1", ho, po, vo, SRC);
        end
    endtask

    initial begin
        rst_in         = 1'b1;
        centroids_x_in = '0;
        centroids_y_in = '0;
        num_balls      = 3'd0;
        data_valid_in  = 1'b0;
        new_frame      = 1'b0;
        hcount_in      = 9'd0;
        vcount_in      = 8'd0;
        pixel_valid_in = 1'b0;
        pixel_in       = 16'h0;
        test_reset();
        test_passthrough();
        test_single();
        test_overlap();
        test_disabled();
        test_all_seven();
        test_mid_frame();
        test_edges();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
